// File: rtl/noc_vc_input_buffer.sv
// Receiver-side NoC input port: per-VC first-word-fall-through flit FIFOs with a
// write-side packet FSM that tracks header/tail framing and flags protocol errors.
module noc_vc_input_buffer #(
    parameter int Channel    = 4,
    parameter int Data_width = 32,
    parameter int Depth      = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [Channel-1:0]            in_valid,
    output logic [Channel-1:0]            in_ready,
    input  logic [Channel*Data_width-1:0] in_flit,
    input  logic [Channel-1:0]            in_is_header,
    input  logic [Channel-1:0]            in_is_tail,
    output logic [Channel-1:0]            in_vc_ready,
    output logic [Channel-1:0]            out_valid,
    input  logic [Channel-1:0]            out_ready,
    output logic [Channel*Data_width-1:0] out_flit,
    output logic [Channel-1:0]            out_is_header,
    output logic [Channel-1:0]            out_is_tail,
    output logic [Channel-1:0]            err_vc
);

    localparam int CW = $clog2(Depth + 1);
    localparam int PW = $clog2(Depth);
    localparam int EW = Data_width + 2;
    localparam logic [CW-1:0] DEPTH_C = CW'(Depth);
    localparam logic [PW-1:0] LAST_C  = PW'(Depth - 1);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DRAIN
    } vc_state_e;

    vc_state_e        state_q  [Channel];
    vc_state_e        state_d  [Channel];
    logic [CW-1:0]    count_q  [Channel];
    logic [CW-1:0]    count_d  [Channel];
    logic [PW-1:0]    wr_ptr_q [Channel];
    logic [PW-1:0]    wr_ptr_d [Channel];
    logic [PW-1:0]    rd_ptr_q [Channel];
    logic [PW-1:0]    rd_ptr_d [Channel];
    logic [Channel-1:0] err_q;
    logic [Channel-1:0] err_d;
    // Entry layout: {header, tail, flit}
    logic [EW-1:0]    mem_q    [Channel][Depth];
    logic [EW-1:0]    mem_d    [Channel][Depth];

    logic [Channel-1:0] push_v;
    logic [Channel-1:0] pop_v;
    logic [Channel-1:0] store_v;

    always_comb begin
        in_ready      = '0;
        out_valid     = '0;
        in_vc_ready   = '0;
        out_flit      = '0;
        out_is_header = '0;
        out_is_tail   = '0;
        for (int unsigned v = 0; v < Channel; v++) begin
            in_ready[v]    = (count_q[v] < DEPTH_C);
            out_valid[v]   = (count_q[v] != '0);
            in_vc_ready[v] = (state_q[v] == IDLE) && (count_q[v] == '0);
            out_flit[v*Data_width +: Data_width] = mem_q[v][rd_ptr_q[v]][Data_width-1:0];
            out_is_header[v] = mem_q[v][rd_ptr_q[v]][Data_width+1];
            out_is_tail[v]   = mem_q[v][rd_ptr_q[v]][Data_width];
        end
    end

    assign err_vc = err_q;

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        err_d    = err_q;
        mem_d    = mem_q;
        push_v   = '0;
        pop_v    = '0;
        store_v  = '0;
        for (int unsigned v = 0; v < Channel; v++) begin
            push_v[v] = in_valid[v] & in_ready[v];
            pop_v[v]  = out_valid[v] & out_ready[v];

            case (state_q[v])
                IDLE, DRAIN: begin
                    if (push_v[v]) begin
                        if (in_is_header[v]) begin
                            store_v[v] = 1'b1;
                            state_d[v] = in_is_tail[v] ? DRAIN : BUSY;
                        end else begin
                            err_d[v] = 1'b1;
                        end
                    end
                end
                BUSY: begin
                    if (push_v[v]) begin
                        store_v[v] = 1'b1;
                        if (in_is_header[v]) err_d[v] = 1'b1;
                        if (in_is_tail[v])   state_d[v] = DRAIN;
                    end
                end
                default: state_d[v] = IDLE;
            endcase

            if (store_v[v]) begin
                mem_d[v][wr_ptr_q[v]] = {in_is_header[v], in_is_tail[v],
                                         in_flit[v*Data_width +: Data_width]};
                wr_ptr_d[v] = (wr_ptr_q[v] == LAST_C) ? '0 : wr_ptr_q[v] + PW'(1);
            end
            if (pop_v[v]) begin
                rd_ptr_d[v] = (rd_ptr_q[v] == LAST_C) ? '0 : rd_ptr_q[v] + PW'(1);
            end

            case ({store_v[v], pop_v[v]})
                2'b10:   count_d[v] = count_q[v] + CW'(1);
                2'b01:   count_d[v] = count_q[v] - CW'(1);
                default: ;
            endcase

            // A drained VC returns to IDLE only on a quiet cycle, so in_vc_ready never
            // rises in the same cycle a new header is being written.
            if ((state_q[v] == DRAIN) && !push_v[v] && (count_d[v] == '0)) begin
                state_d[v] = IDLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned v = 0; v < Channel; v++) begin
                state_q[v]  <= IDLE;
                count_q[v]  <= '0;
                wr_ptr_q[v] <= '0;
                rd_ptr_q[v] <= '0;
            end
            err_q <= '0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            err_q    <= err_d;
        end
    end

    // Payload storage needs no reset: it is only observed while count is non-zero.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: tb/tb_noc_vc_input_buffer.sv
// Scoreboard bench for noc_vc_input_buffer: stimulus queues expected flits per VC,
// a negedge monitor pops and compares every accepted output handshake.
module tb_noc_vc_input_buffer;

    localparam int NCH = 4;
    localparam int DW  = 32;
    localparam int DEP = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic [NCH-1:0]    in_valid;
    logic [NCH-1:0]    in_ready;
    logic [NCH*DW-1:0] in_flit;
    logic [NCH-1:0]    in_is_header;
    logic [NCH-1:0]    in_is_tail;
    logic [NCH-1:0]    in_vc_ready;
    logic [NCH-1:0]    out_valid;
    logic [NCH-1:0]    out_ready;
    logic [NCH*DW-1:0] out_flit;
    logic [NCH-1:0]    out_is_header;
    logic [NCH-1:0]    out_is_tail;
    logic [NCH-1:0]    err_vc;

    int tests_run = 0;
    int tests_failed = 0;

    logic [DW+1:0] exp_q [NCH][$];

    noc_vc_input_buffer #(
        .Channel   (NCH),
        .Data_width(DW),
        .Depth     (DEP)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_flit      (in_flit),
        .in_is_header (in_is_header),
        .in_is_tail   (in_is_tail),
        .in_vc_ready  (in_vc_ready),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_flit     (out_flit),
        .out_is_header(out_is_header),
        .out_is_tail  (out_is_tail),
        .err_vc       (err_vc)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every output handshake must match the oldest expected flit of that VC.
    always @(negedge clk) begin
        if (!rst) begin
            for (int v = 0; v < NCH; v++) begin
                if (out_valid[v] && out_ready[v]) begin
                    if (exp_q[v].size() == 0) begin
                        tests_run++;
                        tests_failed++;
                        $display("FAIL sb_unexpected vc%0d: got flit 0x%0h, expected none at %0t",
                                 v, out_flit[v*DW +: DW], $time);
                    end else begin
                        check($sformatf("sb_pop vc%0d", v),
                              {30'd0, out_is_header[v], out_is_tail[v], out_flit[v*DW +: DW]},
                              {30'd0, exp_q[v].pop_front()});
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int v, input logic [DW-1:0] flit, input logic h,
                        input logic t, input logic stored);
        in_valid[v]          = 1'b1;
        in_flit[v*DW +: DW]  = flit;
        in_is_header[v]      = h;
        in_is_tail[v]        = t;
        if (stored) exp_q[v].push_back({h, t, flit});
        tick();
        in_valid[v]     = 1'b0;
        in_is_header[v] = 1'b0;
        in_is_tail[v]   = 1'b0;
    endtask

    task automatic do_reset(input int cycles);
        rst = 1'b1;
        for (int v = 0; v < NCH; v++) exp_q[v].delete();
        repeat (cycles) tick();
        rst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        in_valid     = '0;
        in_flit      = '0;
        in_is_header = '0;
        in_is_tail   = '0;
        out_ready    = '0;
        rst          = 1'b1;

        // 1. reset and idle
        repeat (2) tick();
        check("rst_in_ready",    in_ready,    4'hF);
        check("rst_in_vc_ready", in_vc_ready, 4'hF);
        check("rst_out_valid",   out_valid,   4'h0);
        check("rst_err_vc",      err_vc,      4'h0);
        rst = 1'b0;
        tick();
        check("idle_out_valid",  out_valid,   4'h0);
        check("idle_in_ready",   in_ready,    4'hF);

        // 2. four-flit packet on VC0, stalled then drained
        push(0, 32'hA0, 1'b1, 1'b0, 1'b1);
        check("t2_vc_ready_busy", in_vc_ready[0], 1'b0);
        push(0, 32'hA1, 1'b0, 1'b0, 1'b1);
        push(0, 32'hA2, 1'b0, 1'b0, 1'b1);
        push(0, 32'hA3, 1'b0, 1'b1, 1'b1);
        check("t2_full_in_ready", in_ready[0],    1'b0);
        check("t2_full_vc_ready", in_vc_ready[0], 1'b0);
        check("t2_full_valid",    out_valid[0],   1'b1);
        out_ready[0] = 1'b1;
        repeat (3) tick();
        check("t2_last_vc_ready", in_vc_ready[0], 1'b0);
        tick();
        check("t2_done_vc_ready", in_vc_ready[0], 1'b1);
        check("t2_done_valid",    out_valid[0],   1'b0);
        out_ready[0] = 1'b0;

        // 3. full VC1 with simultaneous push attempt and pop
        push(1, 32'h10, 1'b1, 1'b0, 1'b1);
        push(1, 32'h11, 1'b0, 1'b0, 1'b1);
        push(1, 32'h12, 1'b0, 1'b0, 1'b1);
        push(1, 32'h13, 1'b0, 1'b0, 1'b1);
        check("t3_full_in_ready", in_ready[1], 1'b0);
        in_valid[1]         = 1'b1;
        in_flit[1*DW +: DW] = 32'h14;
        out_ready[1]        = 1'b1;
        tick();
        check("t3_after_pop_in_ready", in_ready[1], 1'b1);
        exp_q[1].push_back({1'b0, 1'b0, 32'h14});
        tick();
        check("t3_pushpop_in_ready", in_ready[1], 1'b1);
        out_ready[1] = 1'b0;
        in_valid[1]  = 1'b0;
        push(1, 32'h15, 1'b0, 1'b1, 1'b1);
        check("t3_count3_then_full", in_ready[1], 1'b0);
        out_ready[1] = 1'b1;
        repeat (4) tick();
        check("t3_drained_vc_ready", in_vc_ready[1], 1'b1);
        out_ready[1] = 1'b0;

        // 4. interleaved single-flit packets on VC2/VC3
        out_ready[3:2] = 2'b11;
        for (int i = 0; i < 4; i++) begin
            automatic int vc = (i % 2 == 0) ? 2 : 3;
            push(vc, (vc == 2) ? 32'h22 : 32'h33, 1'b1, 1'b1, 1'b1);
            check($sformatf("t4_latency_%0d", i), out_valid[3:2], (vc == 2) ? 2'b01 : 2'b10);
            check($sformatf("t4_flit_%0d", i), out_flit[vc*DW +: DW], (vc == 2) ? 32'h22 : 32'h33);
        end
        tick();
        check("t4_vc_ready", in_vc_ready[3:2], 2'b11);
        check("t4_no_err",   err_vc,           4'h0);
        out_ready[3:2] = 2'b00;

        // 5. body flit on idle VC0 is dropped and sets a sticky error
        out_ready[0] = 1'b1;
        push(0, 32'h55, 1'b0, 1'b0, 1'b0);
        check("t5_dropped_valid", out_valid[0], 1'b0);
        check("t5_err_set",       err_vc,       4'h1);
        repeat (3) tick();
        check("t5_err_sticky",    err_vc,       4'h1);
        push(0, 32'h5A, 1'b1, 1'b1, 1'b1);
        tick();
        check("t5_err_still",     err_vc,       4'h1);
        out_ready[0] = 1'b0;

        // header inside a packet is kept but flagged
        out_ready[3] = 1'b1;
        push(3, 32'h30, 1'b1, 1'b0, 1'b1);
        push(3, 32'h31, 1'b1, 1'b0, 1'b1);
        push(3, 32'h32, 1'b0, 1'b1, 1'b1);
        check("t5_busy_hdr_err",  err_vc,       4'h9);
        repeat (2) tick();
        out_ready[3] = 1'b0;

        // 6. reset in the middle of a VC1 packet
        push(1, 32'h60, 1'b1, 1'b0, 1'b1);
        push(1, 32'h61, 1'b0, 1'b0, 1'b1);
        check("t6_pre_valid",    out_valid[1],   1'b1);
        check("t6_pre_vc_ready", in_vc_ready[1], 1'b0);
        do_reset(1);
        check("t6_post_valid",    out_valid[1],   1'b0);
        check("t6_post_vc_ready", in_vc_ready[1], 1'b1);
        check("t6_post_err",      err_vc,         4'h0);
        out_ready[1] = 1'b1;
        push(1, 32'h62, 1'b1, 1'b1, 1'b1);
        repeat (3) tick();
        out_ready = '0;

        for (int v = 0; v < NCH; v++) begin
            check($sformatf("sb_drained vc%0d", v), exp_q[v].size(), 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
